// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg
// Shared fetch-mux select codes and fetch-controller state encoding.
// Rev 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [3:0] {
        SEL_INIT   = 4'h0,
        SEL_NEXT   = 4'h1,
        SEL_BRANCH = 4'h2,
        SEL_EXC    = 4'h3,
        SEL_HOLD   = 4'h4
    } sel_t;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SHADOW = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// fetch_ctrl_if
// Control/status bundle between the fetch controller and its environment.
// Rev 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    import fetch_pkg::*;

    logic             run;
    logic             stall;
    logic             branch_taken;
    logic             exc_req;
    logic             halt_req;
    logic             resume;
    sel_t             sel;
    logic             fetch_en;
    logic             flush;
    logic             instr_valid;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  run, stall, branch_taken, exc_req, halt_req, resume,
        output sel, fetch_en, flush, instr_valid, halted, fetch_count
    );

    modport slave (
        output run, stall, branch_taken, exc_req, halt_req, resume,
        input  sel, fetch_en, flush, instr_valid, halted, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// fetch_ctrl_cnt
// Free-running fetch counter with enable and synchronous clear; wraps silently.
// Rev 1.0 - initial release
// ============================================================================
module fetch_ctrl_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl
// Fetch sequencing FSM: boot, sequential fetch, redirect shadow and halt.
// Rev 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);
    state_t           r_state;
    state_t           w_next;
    sel_t             w_sel;
    logic             w_fetch_en;
    logic             w_flush;
    logic             r_instr_valid;
    logic             r_halted;
    logic [CNT_W-1:0] w_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_BOOT: begin
                if (bus.run) w_next = ST_RUN;
            end
            ST_RUN, ST_SHADOW: begin
                if (bus.halt_req) begin
                    w_next = ST_HALT;
                end else if (bus.exc_req) begin
                    w_next = ST_SHADOW;
                end else if (bus.branch_taken && (r_state == ST_RUN)) begin
                    w_next = ST_SHADOW;
                end else if (!bus.stall) begin
                    w_next = ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.resume) w_next = ST_RUN;
            end
            default: w_next = ST_BOOT;
        endcase
    end

    // A branch seen while in SHADOW is on the wrong path and is dropped.
    always_comb begin
        w_sel      = SEL_HOLD;
        w_fetch_en = 1'b0;
        w_flush    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_sel      = SEL_INIT;
                w_fetch_en = bus.run;
            end
            ST_RUN, ST_SHADOW: begin
                if (bus.halt_req) begin
                    w_flush = 1'b1;
                end else if (bus.exc_req) begin
                    w_sel      = SEL_EXC;
                    w_fetch_en = 1'b1;
                    w_flush    = 1'b1;
                end else if (bus.branch_taken && (r_state == ST_RUN)) begin
                    w_sel      = SEL_BRANCH;
                    w_fetch_en = 1'b1;
                    w_flush    = 1'b1;
                end else if (!bus.stall) begin
                    w_sel      = SEL_NEXT;
                    w_fetch_en = 1'b1;
                end
            end
            default: begin
                w_sel = SEL_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_en;
            r_halted      <= (w_next == ST_HALT);
        end
    end

    fetch_ctrl_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_fetch_en),
        .clear (1'b0),
        .count (w_count)
    );

    assign bus.sel         = w_sel;
    assign bus.fetch_en    = w_fetch_en;
    assign bus.flush       = w_flush;
    assign bus.instr_valid = r_instr_valid;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = w_count;
endmodule
`default_nettype wire
